// File: rtl/axi_write_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_write_mux_if
//  Brief    : One AXI write port (AW, W, B channels) with master/slave views.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_write_mux_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [ID_W-1:0]       awid;
   logic [7:0]            awlen;

   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast;

   logic                  bvalid;
   logic                  bready;
   logic [ID_W-1:0]       bid;
   logic [1:0]            bresp;

   modport master (
      output awvalid, awaddr, awid, awlen,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready
   );
endinterface

`default_nettype wire

// File: rtl/axi_write_mux.sv
`default_nettype none
// ============================================================================
//  Module   : axi_write_mux
//  Brief    : Routes one AXI write (AW, W burst, B) from the granted master
//             (s0/s1) to slave port m; owner is locked until B completes.
//             Optional burst-length checker: define AXI_WMUX_WLEN_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module axi_write_mux #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  wire              clk,
   input  wire              reset,
   input  wire              arb_state,
   axi_write_mux_if.slave   s0,
   axi_write_mux_if.slave   s1,
   axi_write_mux_if.master  m,
   output logic             busy,
   output logic             len_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;

   logic                 w_own_awvalid;
   logic [ADDR_W-1:0]    w_own_awaddr;
   logic [ID_W-1:0]      w_own_awid;
   logic [7:0]           w_own_awlen;
   logic                 w_own_wvalid;
   logic [DATA_W-1:0]    w_own_wdata;
   logic [DATA_W/8-1:0]  w_own_wstrb;
   logic                 w_own_wlast;
   logic                 w_own_bready;

`ifdef AXI_WMUX_WLEN_CHECK_EN
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic [7:0] exp_len_q, exp_len_d;
   logic       len_err_q, len_err_d;
`endif

   // Owner's request signals; everything downstream muxes on owner_q only.
   always_comb begin
      if (owner_q) begin
         w_own_awvalid = s1.awvalid;
         w_own_awaddr  = s1.awaddr;
         w_own_awid    = s1.awid;
         w_own_awlen   = s1.awlen;
         w_own_wvalid  = s1.wvalid;
         w_own_wdata   = s1.wdata;
         w_own_wstrb   = s1.wstrb;
         w_own_wlast   = s1.wlast;
         w_own_bready  = s1.bready;
      end else begin
         w_own_awvalid = s0.awvalid;
         w_own_awaddr  = s0.awaddr;
         w_own_awid    = s0.awid;
         w_own_awlen   = s0.awlen;
         w_own_wvalid  = s0.wvalid;
         w_own_wdata   = s0.wdata;
         w_own_wstrb   = s0.wstrb;
         w_own_wlast   = s0.wlast;
         w_own_bready  = s0.bready;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
`ifdef AXI_WMUX_WLEN_CHECK_EN
      beat_cnt_d = beat_cnt_q;
      exp_len_d  = exp_len_q;
      len_err_d  = len_err_q;
`endif

      // Payloads always follow the owner; only valids/readies are gated by state.
      m.awvalid  = 1'b0;
      m.awaddr   = w_own_awaddr;
      m.awid     = w_own_awid;
      m.awlen    = w_own_awlen;
      m.wvalid   = 1'b0;
      m.wdata    = w_own_wdata;
      m.wstrb    = w_own_wstrb;
      m.wlast    = w_own_wlast;
      m.bready   = 1'b0;

      s0.awready = 1'b0;
      s0.wready  = 1'b0;
      s0.bvalid  = 1'b0;
      s0.bid     = m.bid;
      s0.bresp   = m.bresp;
      s1.awready = 1'b0;
      s1.wready  = 1'b0;
      s1.bvalid  = 1'b0;
      s1.bid     = m.bid;
      s1.bresp   = m.bresp;

      case (state_q)
         ST_IDLE: begin
            if (s0.awvalid || s1.awvalid) begin
               owner_d = arb_state;
               state_d = ST_ADDR;
            end
         end

         ST_ADDR: begin
            m.awvalid = w_own_awvalid;
            if (owner_q) s1.awready = m.awready;
            else         s0.awready = m.awready;
            if (w_own_awvalid && m.awready) begin
               state_d = ST_DATA;
`ifdef AXI_WMUX_WLEN_CHECK_EN
               exp_len_d  = w_own_awlen;
               beat_cnt_d = 8'd0;
`endif
            end
         end

         ST_DATA: begin
            m.wvalid = w_own_wvalid;
            if (owner_q) s1.wready = m.wready;
            else         s0.wready = m.wready;
            if (w_own_wvalid && m.wready) begin
`ifdef AXI_WMUX_WLEN_CHECK_EN
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (w_own_wlast) begin
                  if (beat_cnt_q != exp_len_q) len_err_d = 1'b1;
                  state_d = ST_RESP;
               end else if (beat_cnt_q == exp_len_q) begin
                  // Burst overran awlen: flag it and close the burst anyway.
                  len_err_d = 1'b1;
                  state_d   = ST_RESP;
               end
`else
               if (w_own_wlast) state_d = ST_RESP;
`endif
            end
         end

         ST_RESP: begin
            m.bready = w_own_bready;
            if (owner_q) s1.bvalid = m.bvalid;
            else         s0.bvalid = m.bvalid;
            if (m.bvalid && w_own_bready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);

`ifdef AXI_WMUX_WLEN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_cnt_q <= 8'd0;
         exp_len_q  <= 8'd0;
         len_err_q  <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         exp_len_q  <= exp_len_d;
         len_err_q  <= len_err_d;
      end
   end

   assign len_err = len_err_q;
`else
   assign len_err = 1'b0;
`endif

endmodule

`default_nettype wire
